mole_board_scorer: RTL and testbench

//  Downstream consumer of the game FSM's mole_clk / game_in_progress outputs.
//  On each mole-up window it picks a pseudo-random mole (LFSR) and lights its LED.
//  It detects player whacks on the hit buttons and keeps the current score and the

---
 rtl/mole_board_scorer.sv | 177 +++++++++++++++++
 tb/tb_mole_board_scorer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_board_scorer.sv
// Whack-a-mole board scorer: lights a pseudo-random mole per mole_clk window,
// judges button whacks and keeps current/best score in saturating BCD.
module mole_board_scorer #(
  parameter int unsigned NUM_MOLES    = 8,
  parameter int unsigned SCORE_DIGITS = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      game_in_progress,
  input  logic                      mole_clk,
  input  logic [NUM_MOLES-1:0]      hit_buttons,
  output logic [NUM_MOLES-1:0]      mole_leds,
  output logic                      hit_pulse,
  output logic                      miss_pulse,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] best_bcd
);

  localparam int unsigned SW        = 4 * SCORE_DIGITS;
  localparam int unsigned IW        = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [SW-1:0] ALL9    = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, DOWN, ARMED, HIT} state_t;

  state_t               state, state_d;
  logic [NUM_MOLES-1:0] btn_s1, btn_s2, btn_q, btn_rise;
  logic                 mole_clk_q, gip_q;
  logic                 mc_rise, mc_fall, gip_rise, gip_fall;
  logic [15:0]          lfsr;
  logic [IW-1:0]        prev_idx, prev_d, idx_raw, idx_sel;
  logic [NUM_MOLES-1:0] leds_d;
  logic [SW-1:0]        score_d;
  logic                 hit_d, miss_d, best_pend;

  // Saturating BCD increment with digit-wise carry.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    if (v != ALL9) begin
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Saturating BCD decrement with digit-wise borrow.
  function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    if (v != '0) begin
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
        if (borrow) begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Button synchroniser plus edge-detect history; game inputs registered once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_q      <= '0;
      mole_clk_q <= 1'b0;
      gip_q      <= 1'b0;
    end else begin
      btn_s1     <= hit_buttons;
      btn_s2     <= btn_s1;
      btn_q      <= btn_s2;
      mole_clk_q <= mole_clk;
      gip_q      <= game_in_progress;
    end
  end

  assign btn_rise = btn_s2 & ~btn_q;
  assign mc_rise  = mole_clk & ~mole_clk_q;
  assign mc_fall  = ~mole_clk & mole_clk_q;
  assign gip_rise = game_in_progress & ~gip_q;
  assign gip_fall = ~game_in_progress & gip_q;

  // Free-running Galois LFSR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // Bump the pick by one when it would repeat the previous mole.
  assign idx_raw = IW'(32'(lfsr[3:0]) % NUM_MOLES);
  assign idx_sel = (idx_raw == prev_idx) ? IW'((32'(idx_raw) + 32'd1) % NUM_MOLES) : idx_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mole_leds  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_bcd  <= '0;
      best_bcd   <= '0;
      prev_idx   <= '0;
      best_pend  <= 1'b0;
    end else begin
      state      <= state_d;
      mole_leds  <= leds_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      score_bcd  <= score_d;
      prev_idx   <= prev_d;
      best_pend  <= gip_fall;
      if (best_pend && (score_bcd > best_bcd)) begin
        best_bcd <= score_bcd;
      end
    end
  end

  // Events are evaluated in strict priority order.
  always_comb begin
    state_d = state;
    leds_d  = mole_leds;
    score_d = score_bcd;
    prev_d  = prev_idx;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (gip_fall) begin
      leds_d  = '0;
      state_d = IDLE;
    end else if (gip_rise && (state == IDLE)) begin
      score_d = '0;
      state_d = DOWN;
    end else if (mc_rise && game_in_progress && ((state == DOWN) || (state == HIT))) begin
      prev_d  = idx_sel;
      leds_d  = NUM_MOLES'(1) << idx_sel;
      state_d = ARMED;
    end else if ((state == ARMED) && mc_fall) begin
      leds_d  = '0;
      state_d = DOWN;
    end else if ((state == ARMED) && (|btn_rise)) begin
      if (btn_rise == mole_leds) begin
        hit_d   = 1'b1;
        score_d = bcd_inc(score_bcd);
        leds_d  = '0;
        state_d = HIT;
      end else begin
        miss_d  = 1'b1;
        score_d = bcd_dec(score_bcd);
      end
    end else if ((state == DOWN) && (|btn_rise)) begin
      miss_d  = 1'b1;
      score_d = bcd_dec(score_bcd);
    end
  end

endmodule

// File: tb/tb_mole_board_scorer.sv
// Randomised + directed bench for mole_board_scorer: an integer-level game model
// feeds an expectation queue that a negedge monitor drains and compares.
module tb_mole_board_scorer;

  localparam int NM = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [7:0]  leds;
    logic        hit;
    logic        miss;
    logic [11:0] score;
    logic [11:0] best;
  } exp_t;

  logic        clk, reset_n, gip, mc;
  logic [7:0]  btn, leds;
  logic        hit, miss;
  logic [11:0] score, best;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state (integer view of the game).
  logic [15:0] m_lfsr;
  int          m_prev, m_lit, m_score, m_best;
  bit          m_in_game, m_caught, m_pend, mc_p, gip_p;
  logic [7:0]  h1, h2, h3;

  // Window tracking for the no-repeat / coverage rule.
  int         last_win, windows, win_idx;
  logic [7:0] seen, prev_leds_obs;

  mole_board_scorer #(.NUM_MOLES(8), .SCORE_DIGITS(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .game_in_progress(gip), .mole_clk(mc),
    .hit_buttons(btn), .mole_leds(leds), .hit_pulse(hit), .miss_pulse(miss),
    .score_bcd(score), .best_bcd(best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model, evaluated at each active edge from the applied inputs.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] press;
    bit         mcr, mcf, gr, gf, h, m;
    int         idx;
    h = 0;
    m = 0;
    if (!reset_n) begin
      m_lfsr = SEED; m_prev = 0; m_lit = -1; m_in_game = 0; m_caught = 0;
      m_score = 0; m_best = 0; m_pend = 0; h1 = '0; h2 = '0; h3 = '0;
      mc_p = 0; gip_p = 0;
    end else begin
      press = h2 & ~h3;
      mcr = mc && !mc_p;
      mcf = !mc && mc_p;
      gr  = gip && !gip_p;
      gf  = !gip && gip_p;
      if (m_pend) begin
        if (m_score > m_best) m_best = m_score;
        m_pend = 0;
      end
      if (gf) begin
        m_lit = -1; m_in_game = 0; m_caught = 0; m_pend = 1;
      end else if (gr && !m_in_game) begin
        m_score = 0; m_in_game = 1; m_lit = -1; m_caught = 0;
      end else if (m_in_game && m_lit < 0 && mcr && gip) begin
        idx = int'(m_lfsr[3:0]) % NM;
        if (idx == m_prev) idx = (idx + 1) % NM;
        m_prev = idx; m_lit = idx; m_caught = 0;
      end else if (m_in_game && m_lit >= 0 && mcf) begin
        m_lit = -1;
      end else if (m_in_game && m_lit >= 0 && press != 0) begin
        if (press == 8'(1 << m_lit)) begin
          h = 1; m_lit = -1; m_caught = 1;
          if (m_score < 999) m_score++;
        end else begin
          m = 1;
          if (m_score > 0) m_score--;
        end
      end else if (m_in_game && m_lit < 0 && !m_caught && press != 0) begin
        m = 1;
        if (m_score > 0) m_score--;
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      h3 = h2; h2 = h1; h1 = btn;
      mc_p = mc; gip_p = gip;
    end
    e.leds  = (m_lit >= 0) ? 8'(1 << m_lit) : 8'h00;
    e.hit   = h;
    e.miss  = m;
    e.score = to_bcd(m_score);
    e.best  = to_bcd(m_best);
    exp_q.push_back(e);
  end

  // Monitor: drains the expectation queue once per cycle, tracks mole windows.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_win      = 0;
      prev_leds_obs = '0;
    end else if (leds != 8'h00 && prev_leds_obs == 8'h00) begin
      win_idx = 0;
      for (int i = 0; i < NM; i++) if (leds[i]) win_idx = i;
      windows++;
      n_checks++;
      if (!$onehot(leds) || win_idx == last_win) begin
        n_fail++;
        $display("FAIL no_repeat t=%0t leds=%h actual_idx=%0d previous_idx=%0d (must be one-hot and differ)",
                 $time, leds, win_idx, last_win);
      end
      seen[win_idx] = 1'b1;
      last_win      = win_idx;
    end
    if (reset_n) prev_leds_obs = leds;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!reset_n) e = '0;
      n_checks++;
      if (leds !== e.leds || hit !== e.hit || miss !== e.miss || score !== e.score || best !== e.best) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t actual leds=%h hit=%b miss=%b score=%h best=%h expected leds=%h hit=%b miss=%b score=%h best=%h",
                 $time, leds, hit, miss, score, best, e.leds, e.hit, e.miss, e.score, e.best);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mole window in which the lit mole is whacked.
  task automatic hit_window();
    mc = 1'b1;
    tick(1);
    if (m_lit >= 0) btn = 8'(1 << m_lit);
    tick(1);
    btn = '0;
    tick(3);
    mc = 1'b0;
    tick(2);
  endtask

  initial begin
    int lit;
    reset_n = 1'b0; gip = 1'b0; mc = 1'b0; btn = '0;
    windows = 0; seen = '0; last_win = 0; prev_leds_obs = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("t1_leds", 32'(leds), 32'h0);
    chk("t1_score", 32'(score), 32'h0);
    chk("t1_best", 32'(best), 32'h0);

    // T2: single hit, 3-cycle whack latency, holding adds nothing.
    gip = 1'b1; tick(2);
    mc = 1'b1; tick(1);
    lit = m_lit;
    chk("t2_lit", 32'(leds), 32'(8'(1 << lit)));
    btn = 8'(1 << lit);
    tick(3);
    chk("t2_hit_pulse", 32'(hit), 32'h1);
    chk("t2_score", 32'(score), 32'h001);
    chk("t2_leds_off", 32'(leds), 32'h0);
    tick(4);
    chk("t2_hold", 32'(score), 32'h001);
    btn = '0; mc = 1'b0; tick(2);
    gip = 1'b0; tick(3);

    // T3: lit + unlit in the same cycle is a miss; score saturates at 0.
    gip = 1'b1; tick(2);
    mc = 1'b1; tick(1);
    lit = m_lit;
    btn = 8'(1 << lit) | 8'(1 << ((lit + 1) % NM));
    tick(3);
    chk("t3_miss_pulse", 32'(miss), 32'h1);
    chk("t3_score", 32'(score), 32'h0);
    chk("t3_still_lit", 32'(leds), 32'(8'(1 << lit)));
    btn = '0; mc = 1'b0; tick(2);
    gip = 1'b0; tick(3);

    // T6: game end while armed, best tracking, reset mid-game.
    gip = 1'b1; tick(2);
    repeat (5) hit_window();
    mc = 1'b1; tick(1);
    gip = 1'b0; tick(1);
    chk("t6_leds_off", 32'(leds), 32'h0);
    tick(1);
    chk("t6_best5", 32'(best), 32'h005);
    mc = 1'b0; tick(2);
    gip = 1'b1; tick(2);
    repeat (3) hit_window();
    gip = 1'b0; tick(3);
    chk("t6_score3", 32'(score), 32'h003);
    chk("t6_best_holds", 32'(best), 32'h005);
    gip = 1'b1; tick(2);
    repeat (2) hit_window();
    mc = 1'b1; tick(1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_leds", 32'(leds), 32'h0);
    chk("t6_rst_score", 32'(score), 32'h0);
    chk("t6_rst_best", 32'(best), 32'h0);
    mc = 1'b0; tick(2);
    reset_n = 1'b1; tick(2);

    // T4: ramp to saturation, then one miss.
    for (int i = 1; i <= 1000; i++) begin
      hit_window();
      if (i == 99)   chk("t4_099", 32'(score), 32'h099);
      if (i == 100)  chk("t4_100", 32'(score), 32'h100);
      if (i == 999)  chk("t4_999", 32'(score), 32'h999);
      if (i == 1000) chk("t4_sat", 32'(score), 32'h999);
    end
    mc = 1'b1; tick(1);
    btn = 8'(1 << ((m_lit + 1) % NM));
    tick(1);
    btn = '0;
    tick(3);
    chk("t4_998", 32'(score), 32'h998);
    mc = 1'b0; tick(2);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) mc = ~mc;
      btn = '0;
      r = int'($urandom_range(0, 99));
      if (r < 10 && m_lit >= 0) btn = 8'(1 << m_lit);
      else if (r < 15) btn = 8'($urandom);
      if ($urandom_range(0, 299) == 0) gip = ~gip;
      tick(1);
    end
    gip = 1'b0; mc = 1'b0; btn = '0;
    tick(5);

    chk("t5_windows", 32'(windows >= 200), 32'h1);
    chk("t5_all_seen", 32'(seen), 32'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
